// File: rtl/sram_mem_controller_pkg.sv
// Shared definitions for the MEM-stage SRAM controller.
//   state_t      : controller FSM encoding (2 bits)
//   DM_BASE_DEF  : default byte address mapped to SRAM word 0
//   SRAM_ADDR_W  : SRAM half-word address width (256K x 16)
//   SRAM_DW      : SRAM data bus width
package sram_mem_controller_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int DM_BASE_DEF = 1024;
  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DW     = 16;
endpackage

// File: rtl/sram_dq_tristate.sv
// Bidirectional buffer for the SRAM data bus.
//   i_oe   : 1 = drive i_dout onto io_dq, 0 = release bus (Z)
//   i_dout : value driven during writes
//   o_din  : bus value as seen by the controller (read path)
//   io_dq  : SRAM data pins
module sram_dq_tristate #(
  parameter int W = 16
) (
  input  logic         i_oe,
  input  logic [W-1:0] i_dout,
  output logic [W-1:0] o_din,
  inout  wire  [W-1:0] io_dq
);
  assign io_dq = i_oe ? i_dout : {W{1'bz}};
  assign o_din = io_dq;
endmodule

// File: rtl/sram_mem_controller.sv
// Multi-cycle bridge between the MEM stage and a 256K x 16 SRAM.
// A 32-bit access is split into two half-word transfers, low half first,
// each held for HALF_CYCLES clocks. ready is low while a transfer is in
// flight so the pipeline freezes around it.
//   clk, rst          : clock, synchronous active-low reset
//   wr_en, rd_en      : level requests, held until ready (write wins)
//   address           : word-aligned byte address
//   write_data        : store value
//   read_data         : load result, valid when ready rises after a load
//   ready             : idle with no request, or access completing
//   SRAM_*            : SRAM pins (CE/UB/LB tied active)
module sram_mem_controller
  import sram_mem_controller_pkg::*;
#(
  parameter int HALF_CYCLES = 2,
  parameter int DM_BASE     = DM_BASE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DW-1:0]     SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N
);
  localparam int CNT_W = $clog2(HALF_CYCLES);

  state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic                   r_op_wr;
  logic [31:0]            r_read_data;

  logic                   w_req, w_last, w_busy, w_half, w_dq_oe;
  logic [SRAM_DW-1:0]     w_dout, w_din;
  logic [31:0]            w_offs;
  logic [SRAM_ADDR_W-2:0] w_widx;
  logic                   w_unused;

  assign w_req  = rd_en | wr_en;
  assign w_last = (r_cnt == CNT_W'(HALF_CYCLES - 1));

  // Out-of-window addresses simply wrap through the truncation.
  assign w_offs   = address - 32'(DM_BASE);
  assign w_widx   = w_offs[SRAM_ADDR_W:2];
  assign w_unused = ^{w_offs[31:SRAM_ADDR_W+1], w_offs[1:0]};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_wr     <= 1'b0;
      r_read_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && w_req) r_op_wr <= wr_en;
      // Sample on the hold cycle of each half; SRAM data has settled.
      if (!r_op_wr && w_last) begin
        if (r_state == LO) r_read_data[15:0]  <= w_din;
        if (r_state == HI) r_read_data[31:16] <= w_din;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_req) begin
        w_state_nxt = LO;
        w_cnt_nxt   = '0;
      end
      LO: if (w_last) begin
        w_state_nxt = HI;
        w_cnt_nxt   = '0;
      end else w_cnt_nxt = r_cnt + CNT_W'(1);
      HI: if (w_last) begin
        w_state_nxt = DONE;
        w_cnt_nxt   = '0;
      end else w_cnt_nxt = r_cnt + CNT_W'(1);
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_busy  = (r_state == LO) || (r_state == HI);
  assign w_half  = (r_state == HI);
  assign w_dq_oe = w_busy & r_op_wr;
  assign w_dout  = w_half ? write_data[31:16] : write_data[15:0];

  assign ready     = (r_state == IDLE && !w_req) || (r_state == DONE);
  assign read_data = r_read_data;
  assign SRAM_ADDR = w_busy ? {w_widx, w_half} : '0;
  // Strobe released on the last cycle of a half so address/data are held
  // across the WE_N rising edge.
  assign SRAM_WE_N = ~(w_dq_oe & ~w_last);
  assign SRAM_OE_N = ~(w_busy & ~r_op_wr);
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;

  sram_dq_tristate #(.W(SRAM_DW)) u_dq (
    .i_oe  (w_dq_oe),
    .i_dout(w_dout),
    .o_din (w_din),
    .io_dq (SRAM_DQ)
  );
endmodule
